// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester/memory bundle shared by the memory port arbiter and its users.
interface mem_port_arbiter_if #(parameter int N = 64);
    logic [2:0]     req;
    logic [2:0]     we;
    logic [3*N-1:0] addr_in;
    logic [3*N-1:0] wdata_in;
    logic [N-1:0]   mem_rdata;
    logic           mem_en;
    logic           mem_we;
    logic [N-1:0]   mem_addr;
    logic [N-1:0]   mem_wdata;
    logic [N-1:0]   rdata;
    logic [2:0]     done;
    logic [2:0]     grant;
    logic           busy;
    modport slave (
        input  req, we, addr_in, wdata_in, mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, rdata, done, grant, busy
    );
    modport master (
        output req, we, addr_in, wdata_in, mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, rdata, done, grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the unified memory port (fetch, load/store, DMA).
// Define ARB_FETCH_PRIORITY_EN to give fetch absolute priority over the other two.
module mem_port_arbiter #(
    parameter int N           = 64,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clock,
    input logic            reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t         state, state_d;
    logic [7:0]     cnt, cnt_d;
    logic [1:0]     last, last_d, win;
    logic           mem_en_d, mem_we_d, busy_d;
    logic [N-1:0]   mem_addr_d, mem_wdata_d, rdata_d, addr_sel, wdata_sel;
    logic [2:0]     done_d, grant_d;
`ifdef ARB_FETCH_PRIORITY_EN
    assign win = bus.req[0] ? 2'd0 :
                 (last == 2'd1) ? (bus.req[2] ? 2'd2 : 2'd1) :
                                  (bus.req[1] ? 2'd1 : 2'd2);
`else
    logic [1:0] c1, c2;
    assign c1  = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign c2  = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    assign win = bus.req[c1] ? c1 : bus.req[c2] ? c2 : last;
`endif
    assign addr_sel  = (win == 2'd0) ? bus.addr_in[0 +: N] :
                       (win == 2'd1) ? bus.addr_in[N +: N] : bus.addr_in[2*N +: N];
    assign wdata_sel = (win == 2'd0) ? bus.wdata_in[0 +: N] :
                       (win == 2'd1) ? bus.wdata_in[N +: N] : bus.wdata_in[2*N +: N];
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last;
        mem_en_d    = bus.mem_en;
        mem_we_d    = bus.mem_we;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        rdata_d     = bus.rdata;
        grant_d     = bus.grant;
        done_d      = 3'b000;
        case (state)
            IDLE: if (bus.req != 3'b000) begin
                mem_addr_d  = addr_sel;
                mem_wdata_d = wdata_sel;
                mem_we_d    = bus.we[win];
                mem_en_d    = 1'b1;
                grant_d     = 3'b001 << win;
                cnt_d       = 8'(WAIT_CYCLES);
`ifdef ARB_FETCH_PRIORITY_EN
                if (win != 2'd0) last_d = win;
`else
                last_d = win;
`endif
                state_d = ACCESS;
            end
            ACCESS: if (cnt != 8'd0) begin
                cnt_d = cnt - 8'd1;
            end else begin
                rdata_d  = bus.mem_we ? bus.rdata : bus.mem_rdata;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                done_d   = bus.grant;
                state_d  = DONE;
            end
            default: begin
                grant_d = 3'b000;
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            last          <= 2'd2;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.done      <= 3'b000;
            bus.grant     <= 3'b000;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            last          <= last_d;
            bus.mem_en    <= mem_en_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.rdata     <= rdata_d;
            bus.done      <= done_d;
            bus.grant     <= grant_d;
            bus.busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random request bursts scored against a service-order model of the arbiter.
module tb_mem_port_arbiter;
    localparam int N = 64;
    localparam int W = 1;
    typedef struct {
        int          id;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          done_cyc;
    } exp_t;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          ptr = 2;
    logic [63:0] model_rdata = '0;
    logic [63:0] a [3];
    logic [63:0] d [3];
    logic [2:0]  wem;
    exp_t        q[$];
    exp_t        m_e;
    mem_port_arbiter_if #(.N(N)) bus();
    mem_port_arbiter #(.N(N), .WAIT_CYCLES(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    function automatic logic [63:0] mem_fn(input logic [63:0] x);
        return (x == 64'h100) ? 64'hDEAD : ({x[31:0], x[63:32]} ^ 64'h0123_4567_89AB_CDEF);
    endfunction
    assign bus.mem_rdata = mem_fn(bus.mem_addr);
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask
    // Monitor: the access in flight is always the queue head until its done pulse pops it.
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            chk("busy", 64'(bus.busy), 64'(bus.mem_en | (|bus.done)));
            if (bus.done != 3'b000) begin
                if (q.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
                else begin
                    m_e = q.pop_front();
                    chk("done", 64'(bus.done), 64'(1 << m_e.id));
                    chk("done_grant", 64'(bus.grant), 64'(1 << m_e.id));
                    chk("done_cycle", 64'(cyc), 64'(m_e.done_cyc));
                    chk("rdata", bus.rdata, m_e.rdata);
                    chk("done_mem_en", 64'(bus.mem_en), 64'd0);
                end
            end else if (bus.mem_en) begin
                if (q.size() == 0) chk("spurious_mem_en", 64'(bus.mem_en), 64'd0);
                else begin
                    chk("mem_addr", bus.mem_addr, q[0].addr);
                    chk("mem_wdata", bus.mem_wdata, q[0].wdata);
                    chk("mem_we", 64'(bus.mem_we), 64'(q[0].we));
                    chk("grant", 64'(bus.grant), 64'(1 << q[0].id));
                end
            end else chk("idle_grant", 64'(bus.grant), 64'd0);
        end
    end
    task automatic run_phase(input logic [2:0] mask);
        int   order[$];
        int   p;
        int   guard;
        exp_t e;
`ifdef ARB_FETCH_PRIORITY_EN
        begin
            int f;
            int s;
            f = (ptr == 1) ? 2 : 1;
            s = 3 - f;
            if (mask[0]) order.push_back(0);
            if (mask[f]) order.push_back(f);
            if (mask[s]) order.push_back(s);
            if (mask[s]) ptr = s;
            else if (mask[f]) ptr = f;
        end
`else
        for (int i = 1; i <= 3; i++)
            if (mask[(ptr + i) % 3]) order.push_back((ptr + i) % 3);
        ptr = order[$];
`endif
        p = cyc + 1;
        foreach (order[k]) begin
            e.id    = order[k];
            e.we    = wem[e.id];
            e.addr  = a[e.id];
            e.wdata = d[e.id];
            if (!e.we) model_rdata = mem_fn(e.addr);
            e.rdata    = model_rdata;
            e.done_cyc = p + 1 + W + k * (W + 3);
            q.push_back(e);
        end
        bus.we       = wem;
        bus.addr_in  = {a[2], a[1], a[0]};
        bus.wdata_in = {d[2], d[1], d[0]};
        bus.req      = mask;
        guard = 0;
        while (bus.req != 3'b000 && guard < 20 * (W + 3)) begin
            @(negedge clock);
            guard++;
            bus.req = bus.req & ~bus.done;
        end
        if (bus.req != 3'b000) begin
            chk("phase_timeout", 64'(bus.req), 64'd0);
            bus.req = 3'b000;
        end
        @(negedge clock);
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask
    task automatic reset_mid();
        mon_en   = 1'b0;
        a[0]     = {$urandom, $urandom};
        wem      = 3'b000;
        bus.we   = wem;
        bus.addr_in = {a[2], a[1], a[0]};
        bus.req  = 3'b001;
        @(negedge clock);
        chk("rm_access_started", 64'(bus.mem_en), 64'd1);
        @(negedge clock);
        reset   = 1'b1;
        bus.req = 3'b000;
        @(negedge clock);
        chk("rm_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rm_done", 64'(bus.done), 64'd0);
        chk("rm_grant", 64'(bus.grant), 64'd0);
        chk("rm_busy", 64'(bus.busy), 64'd0);
        reset       = 1'b0;
        ptr         = 2;
        model_rdata = '0;
        q.delete();
        mon_en = 1'b1;
    endtask
    initial begin
        bus.req = 3'b000;
        bus.we = 3'b000;
        bus.addr_in = '0;
        bus.wdata_in = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        wem = 3'b000;
        repeat (3) @(negedge clock);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        a[0] = 64'h100;
        run_phase(3'b001);
        chk("single_read_rdata", bus.rdata, 64'hDEAD);
        a[1] = 64'h200;
        d[1] = 64'h55;
        wem  = 3'b010;
        run_phase(3'b010);
        chk("write_keeps_rdata", bus.rdata, 64'hDEAD);
        reset_mid();
        wem = 3'b000;
        run_phase(3'b011);
        reset_mid();
        for (int i = 0; i < 3; i++) a[i] = 64'h1000 * (i + 1);
        run_phase(3'b111);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) begin
                a[i] = {$urandom, $urandom};
                d[i] = {$urandom, $urandom};
            end
            wem = 3'($urandom);
            run_phase(3'($urandom_range(1, 7)));
        end
        repeat (5) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the LEGv8 multicycle datapath among three requesters: 0 = instruction fetch (IF state), 1 = data load/store (EX states), 2 = DMA/peripheral.
- Grants one requester at a time using round-robin and latches that requester's address and data.
- Drives the memory for a fixed number of wait states, then returns read data with a one-cycle done pulse.
- The control unit holds its current state while its done is low.

Parameters:
- N, 64, address and data width.
- WAIT_CYCLES, 1, extra memory cycles per access (0..255); the access phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  3  per-requester request level; held until that requester's done.
- we  in  3  per-requester write enable, valid while req is high.
- addr_in  in  3*N  packed addresses; requester i occupies [i*N +: N].
- wdata_in  in  3*N  packed write data, same packing as addr_in.
- mem_rdata  in  N  read data from memory.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  N  memory address.
- mem_wdata  out  N  memory write data.
- rdata  out  N  captured read data, valid in the done cycle and held afterwards.
- done  out  3  one-hot, one-cycle completion pulse.
- grant  out  3  one-hot current owner; 0 when idle.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, last-grant pointer 2 (so requester 0 has first priority after reset).
- Reset mid-operation: abort the access immediately. Next cycle: mem_en=0, no done pulse, pointer returns to 2.
- All outputs are registered.

State machine (IDLE, ACCESS, DONE):
- IDLE:
  - If req != 0, select a winner by round-robin: search order is last+1, last+2, last (mod 3).
  - Latch the winner's addr, wdata and we into mem_addr, mem_wdata and mem_we.
  - Set grant to the winner, mem_en=1, counter=WAIT_CYCLES, pointer=winner; go to ACCESS.
  - If req == 0, stay in IDLE with mem_en=0.
- ACCESS:
  - mem_en stays high and all mem_* outputs are stable.
  - While counter != 0: decrement it and stay in ACCESS.
  - When counter == 0:
    - Capture mem_rdata into rdata if mem_we=0; leave rdata unchanged on writes.
    - Drop mem_en and mem_we.
    - Set done[winner]=1 and go to DONE.
- DONE:
  - done is high for exactly this cycle; grant is held.
  - Next cycle: done=0, grant=0, go to IDLE.
  - req is ignored in DONE.

Latency:
- A req first seen high at edge k gives mem_en high for cycles k+1 .. k+1+WAIT_CYCLES and done high in cycle k+2+WAIT_CYCLES.
- Minimum turnaround is WAIT_CYCLES+3 cycles per access.

Handshake rules:
- A requester keeps req, we, addr and wdata stable until it sees done.
- It must drop req on the edge that ends its done cycle.
- If req is still high in IDLE after that, it counts as a new request.
- Changing addr/data after the grant has no effect, because values are latched at grant.

Simultaneous requests:
- Exactly one grant per IDLE decision; requesters that lose keep waiting.
- With all three requesting continuously, grants rotate 0,1,2,0,...
- No requester waits more than two other accesses.

Widths and wait counter:
- The wait counter is 8 bits.
- WAIT_CYCLES=0 gives a single-cycle ACCESS.

Optional Feature:
- Macro: ARB_FETCH_PRIORITY_EN.
- Defined: requester 0 (fetch) wins whenever req[0] is high in IDLE. Round-robin applies only between requesters 1 and 2, and the pointer is updated only by grants to 1 or 2.
- Undefined: pure three-way round-robin as described above.

Test Plan:
- Single read, WAIT_CYCLES=1: req=3'b001 at cycle 0, addr_in[0]=64'h100, mem_rdata=64'hDEAD -> mem_en high in cycles 1–2 with mem_addr=64'h100; done=3'b001 and rdata=64'hDEAD in cycle 3; grant=0 in cycle 4.
- Write: req=3'b010, we=3'b010, addr=64'h200, wdata=64'h55 -> mem_we=1 and mem_wdata=64'h55 in cycles 1–2; done=3'b010 in cycle 3; rdata unchanged.
- Contention: req=3'b111 held, dropping each bit on its own done -> grant order 0,1,2; done pulses in cycles 3, 7 and 11 (WAIT_CYCLES=1).
- Reset mid-access: reset=1 in cycle 2 of an access -> cycle 3 has mem_en=0, done=0, grant=0; next req=3'b011 is granted to requester 0.
- WAIT_CYCLES=0: req=3'b100 -> mem_en in cycle 1 only; done=3'b100 in cycle 2.
- ARB_FETCH_PRIORITY_EN defined, req=3'b111 held, with requester 0 re-asserting immediately after each done -> requester 0 wins every arbitration; requesters 1 and 2 are granted only in cycles where req[0]=0.
